view_ctrl: RTL and testbench

- Consumes the one-cycle button pulses from the push-button debouncer and maintains the Mandelbrot view state: zoom level, preset centre and per-pixel step.
- Issues render requests to the fractal renderer with a start/done handshake.
- Snapshots the view parameters into output registers at each request, so coordinates stay stable for a whole frame.
- Queues at most one pending request while a render is in flight.

---
 rtl/view_ctrl.sv | 108 ++++++++++
 tb/tb_view_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/view_ctrl.sv
// view_ctrl: Mandelbrot view state and render request sequencer; VIEW_AUTO_ZOOM_EN adds auto-zoom.
module view_ctrl #(
  parameter int                 COORD_W   = 32,
  parameter int                 ZOOM_MAX  = 24,
  parameter logic [COORD_W-1:0] BASE_STEP = 32'h0013_3333
) (
  input  logic                      slow_clk,
  input  logic                      RESET,
  input  logic [3:1]                i_btn,
  input  logic                      i_done,
  output logic                      o_start,
  output logic signed [COORD_W-1:0] o_cx,
  output logic signed [COORD_W-1:0] o_cy,
  output logic [COORD_W-1:0]        o_step,
  output logic [4:0]                o_zoom,
  output logic                      o_busy,
  output logic                      o_auto
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  localparam logic [4:0] ZMAX = 5'(ZOOM_MAX);
  localparam logic signed [COORD_W-1:0] CX0 = COORD_W'(-32'sd134217728);
  localparam logic signed [COORD_W-1:0] CY0 = '0;
  localparam logic signed [COORD_W-1:0] CX1 = COORD_W'(-32'sd199620386);
  localparam logic signed [COORD_W-1:0] CY1 = COORD_W'(32'sd35386747);
  localparam logic signed [COORD_W-1:0] CX2 = COORD_W'(-32'sd335721487);
  localparam logic signed [COORD_W-1:0] CY2 = COORD_W'(32'sd5400921);
  localparam logic signed [COORD_W-1:0] CX3 = COORD_W'(-32'sd27138825);
  localparam logic signed [COORD_W-1:0] CY3 = COORD_W'(32'sd256704827);
  state_t state;
  logic [4:0] zoom, zoom_nxt, zoom_fin;
  logic [1:0] preset, preset_nxt;
  logic vc, pending, auto_step;
  logic signed [COORD_W-1:0] pcx, pcy;
  assign pcx = preset == 2'd0 ? CX0 : preset == 2'd1 ? CX1 : preset == 2'd2 ? CX2 : CX3;
  assign pcy = preset == 2'd0 ? CY0 : preset == 2'd1 ? CY1 : preset == 2'd2 ? CY2 : CY3;
  // Presses at a zoom limit and the reserved zoom-in+zoom-out chord are not view changes
  always_comb begin
    zoom_nxt   = zoom;
    preset_nxt = preset;
    vc         = 1'b0;
    if (i_btn[3]) begin
      preset_nxt = preset + 2'd1;
      zoom_nxt   = '0;
      vc         = 1'b1;
    end else if (i_btn[1] && !i_btn[2] && zoom < ZMAX) begin
      zoom_nxt = zoom + 5'd1;
      vc       = 1'b1;
    end else if (i_btn[2] && !i_btn[1] && zoom != 5'd0) begin
      zoom_nxt = zoom - 5'd1;
      vc       = 1'b1;
    end
  end
  assign zoom_fin = auto_step ? zoom + 5'd1 : zoom_nxt;
`ifdef VIEW_AUTO_ZOOM_EN
  logic auto_q;
  assign auto_step = auto_q && state == S_WAIT && i_done && !pending && !vc && zoom < ZMAX;
  always_ff @(posedge slow_clk)
    auto_q <= RESET ? 1'b0 :
              (i_btn[3] || (i_btn[1] ^ i_btn[2]) || zoom_fin == ZMAX) ? 1'b0 :
              (i_btn[1] && i_btn[2]) ? !auto_q : auto_q;
  assign o_auto = auto_q;
`else
  assign auto_step = 1'b0;
  assign o_auto    = 1'b0;
`endif
  // Snapshot registers load only in S_REQ so they hold for the whole frame
  always_ff @(posedge slow_clk) begin
    if (RESET) begin
      state   <= S_REQ;
      zoom    <= '0;
      preset  <= '0;
      pending <= 1'b0;
      o_start <= 1'b0;
      o_busy  <= 1'b0;
      o_cx    <= CX0;
      o_cy    <= CY0;
      o_step  <= BASE_STEP;
      o_zoom  <= '0;
    end else begin
      zoom   <= zoom_fin;
      preset <= preset_nxt;
      case (state)
        S_IDLE: state <= vc ? S_REQ : S_IDLE;
        S_REQ: begin
          o_cx    <= pcx;
          o_cy    <= pcy;
          o_step  <= BASE_STEP >> zoom;
          o_zoom  <= zoom;
          o_start <= 1'b1;
          o_busy  <= 1'b1;
          pending <= vc;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          o_start <= 1'b0;
          if (i_done) begin
            o_busy  <= 1'b0;
            pending <= 1'b0;
            state   <= (pending || vc || auto_step) ? S_REQ : S_IDLE;
          end else begin
            pending <= pending || vc;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_view_ctrl.sv
// tb_view_ctrl: scoreboard bench for view_ctrl; expected snapshots queued at each press, checked on o_start.
module tb_view_ctrl;
  logic slow_clk = 1'b0, RESET = 1'b1, i_done = 1'b0;
  logic [3:1] i_btn = '0;
  logic o_start, o_busy, o_auto;
  logic signed [31:0] o_cx, o_cy;
  logic [31:0] o_step;
  logic [4:0] o_zoom;
  view_ctrl dut (
    .slow_clk(slow_clk), .RESET(RESET), .i_btn(i_btn), .i_done(i_done),
    .o_start(o_start), .o_cx(o_cx), .o_cy(o_cy), .o_step(o_step),
    .o_zoom(o_zoom), .o_busy(o_busy), .o_auto(o_auto)
  );
  always #5 slow_clk = ~slow_clk;
  typedef struct {
    logic [31:0] cx, cy, step;
    logic [4:0]  zoom;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int passed = 0, total = 0, n_start = 0, mz = 0, mp = 0, s0;
  bit got;
  logic signed [31:0] pcx [4] = '{-32'sd134217728, -32'sd199620386, -32'sd335721487, -32'sd27138825};
  logic signed [31:0] pcy [4] = '{32'sd0, 32'sd35386747, 32'sd5400921, 32'sd256704827};
  task automatic expect_req();
    exp_t e;
    e.cx = pcx[mp]; e.cy = pcy[mp]; e.step = 32'h0013_3333 >> mz; e.zoom = 5'(mz);
    sb.push_back(e);
  endtask
  always @(negedge slow_clk) if (o_start) begin
    n_start++;
    total++;
    if (sb.size() == 0) $display("FAIL unexpected_start: o_start with zoom=%0d, no request expected", o_zoom);
    else begin
      mon_e = sb.pop_front();
      if (o_cx !== mon_e.cx || o_cy !== mon_e.cy || o_step !== mon_e.step || o_zoom !== mon_e.zoom || o_busy !== 1'b1)
        $display("FAIL snapshot: got cx=%h cy=%h step=%h zoom=%0d busy=%b, want cx=%h cy=%h step=%h zoom=%0d busy=1",
                 o_cx, o_cy, o_step, o_zoom, o_busy, mon_e.cx, mon_e.cy, mon_e.step, mon_e.zoom);
      else passed++;
    end
  end
  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge slow_clk); #1; end
  endtask
  task automatic pulse(input logic [3:1] b);
    i_btn = b; cyc(); i_btn = '0;
  endtask
  task automatic done();
    i_done = 1'b1; cyc(); i_done = 1'b0;
  endtask
  task automatic wait_start(input int max, output bit g);
    g = 1'b0;
    for (int i = 0; i <= max; i++) begin
      if (o_start) begin g = 1'b1; break; end
      cyc();
    end
  endtask
  task automatic test_reset();
    RESET = 1'b1; cyc(3);
    total++;
    if (o_start !== 0 || o_busy !== 0 || o_auto !== 0 || o_cx !== 32'hF800_0000 || o_cy !== 0 || o_step !== 32'h0013_3333 || o_zoom !== 0)
      $display("FAIL reset_state: start=%b busy=%b auto=%b cx=%h cy=%h step=%h zoom=%0d, want 0 0 0 f8000000 0 00133333 0",
               o_start, o_busy, o_auto, o_cx, o_cy, o_step, o_zoom);
    else passed++;
    mz = 0; mp = 0; expect_req();
    RESET = 1'b0;
    total++; if (o_start !== 1'b0) $display("FAIL reset_early: o_start=%b want 0", o_start); else passed++;
    cyc();
    total++; if (o_start !== 1'b1) $display("FAIL reset_latency: o_start=%b want 1 on 2nd edge", o_start); else passed++;
    cyc();
    total++; if (o_start !== 1'b0 || o_busy !== 1'b1) $display("FAIL reset_pulse: start=%b busy=%b want 0 1", o_start, o_busy); else passed++;
    cyc(3);
    total++; if (o_busy !== 1'b1) $display("FAIL busy_hold: o_busy=%b want 1", o_busy); else passed++;
    done();
    total++; if (o_busy !== 1'b0) $display("FAIL busy_clear: o_busy=%b want 0", o_busy); else passed++;
  endtask
  task automatic test_zoom_in();
    mz = 1; expect_req();
    pulse(3'b001);
    total++; if (o_start !== 1'b0) $display("FAIL zoom_in_early: o_start=%b want 0", o_start); else passed++;
    cyc();
    total++;
    if (o_start !== 1'b1 || o_step !== 32'h0009_9999 || o_zoom !== 5'd1)
      $display("FAIL zoom_in: start=%b step=%h zoom=%0d want 1 00099999 1", o_start, o_step, o_zoom);
    else passed++;
    done();
  endtask
  task automatic test_back_to_back();
    mz = 0; expect_req();
    pulse(3'b010);
    wait_start(4, got);
    total++; if (!got) $display("FAIL b2b_first: o_start=0 want 1"); else passed++;
    cyc(); s0 = n_start;
    repeat (3) begin pulse(3'b001); cyc(); end
    mz = 3;
    total++;
    if (n_start !== s0 || o_zoom !== 0 || o_cx !== pcx[0] || o_cy !== pcy[0] || o_busy !== 1'b1)
      $display("FAIL b2b_hold: starts=%0d zoom=%0d cx=%h busy=%b want %0d 0 %h 1", n_start, o_zoom, o_cx, o_busy, s0, pcx[0]);
    else passed++;
    expect_req();
    done();
    wait_start(4, got);
    total++; if (!got || o_zoom !== 5'd3) $display("FAIL b2b_collapse: got=%b zoom=%0d want 1 3", got, o_zoom); else passed++;
    cyc(4);
    total++; if (n_start !== s0 + 1) $display("FAIL b2b_once: starts=%0d want %0d", n_start, s0 + 1); else passed++;
    done();
  endtask
  task automatic test_limits();
    repeat (2) begin
      mz++; expect_req(); pulse(3'b001); wait_start(4, got);
      total++; if (!got) $display("FAIL to_zoom5: o_start=0 want 1 zoom=%0d", mz); else passed++;
      done();
    end
    mp = 1; mz = 0; expect_req(); pulse(3'b100); wait_start(4, got);
    total++; if (!got || o_zoom !== 0 || o_cx !== pcx[1]) $display("FAIL preset_next: got=%b zoom=%0d cx=%h want 1 0 %h", got, o_zoom, o_cx, pcx[1]); else passed++;
    done();
    s0 = n_start; pulse(3'b010); cyc(5);
    total++; if (n_start !== s0) $display("FAIL zoom_min: starts=%0d want %0d", n_start, s0); else passed++;
    repeat (24) begin
      mz++; expect_req(); pulse(3'b001); wait_start(4, got);
      total++; if (!got) $display("FAIL climb: o_start=0 want 1 zoom=%0d", mz); else passed++;
      done();
    end
    s0 = n_start; pulse(3'b001); cyc(5);
    total++; if (n_start !== s0 || o_zoom !== 5'd24) $display("FAIL zoom_max: starts=%0d zoom=%0d want %0d 24", n_start, o_zoom, s0); else passed++;
    mz = 0;
    repeat (3) begin
      mp = (mp + 1) % 4; expect_req(); pulse(3'b100); wait_start(4, got);
      total++; if (!got) $display("FAIL preset_wrap_req: o_start=0 want 1 preset=%0d", mp); else passed++;
      done();
    end
    total++; if (o_cx !== pcx[0] || o_cy !== pcy[0]) $display("FAIL preset_wrap: cx=%h cy=%h want %h %h", o_cx, o_cy, pcx[0], pcy[0]); else passed++;
  endtask
  task automatic test_combo();
    mz = 1; expect_req(); pulse(3'b001); wait_start(4, got);
    total++; if (!got) $display("FAIL combo_setup: o_start=0 want 1"); else passed++;
    done();
    mp = (mp + 1) % 4; mz = 0; expect_req(); pulse(3'b101); wait_start(4, got);
    total++; if (!got || o_zoom !== 0 || o_cx !== pcx[1]) $display("FAIL combo_btn13: got=%b zoom=%0d cx=%h want 1 0 %h", got, o_zoom, o_cx, pcx[1]); else passed++;
    done();
`ifndef VIEW_AUTO_ZOOM_EN
    s0 = n_start; pulse(3'b011); cyc(5);
    total++; if (n_start !== s0 || o_auto !== 1'b0) $display("FAIL combo_btn12: starts=%0d auto=%b want %0d 0", n_start, o_auto, s0); else passed++;
`endif
  endtask
`ifdef VIEW_AUTO_ZOOM_EN
  task automatic test_auto();
    mp = 2; mz = 0; expect_req(); pulse(3'b100); wait_start(4, got);
    total++; if (!got) $display("FAIL auto_setup: o_start=0 want 1"); else passed++;
    cyc(); pulse(3'b011);
    total++; if (o_auto !== 1'b1) $display("FAIL auto_on: o_auto=%b want 1", o_auto); else passed++;
    for (int z = 1; z <= 24; z++) begin
      mz = z; expect_req(); done(); wait_start(4, got);
      total++; if (!got || o_zoom !== 5'(z)) $display("FAIL auto_step: got=%b zoom=%0d want 1 %0d", got, o_zoom, z); else passed++;
    end
    cyc();
    total++; if (o_auto !== 1'b0) $display("FAIL auto_off: o_auto=%b want 0", o_auto); else passed++;
    s0 = n_start; done(); cyc(5);
    total++; if (n_start !== s0) $display("FAIL auto_stop: starts=%0d want %0d", n_start, s0); else passed++;
  endtask
`endif
  task automatic test_reset_mid();
    mp = (mp + 1) % 4; mz = 0; expect_req(); pulse(3'b100); wait_start(4, got);
    total++; if (!got) $display("FAIL mid_setup: o_start=0 want 1"); else passed++;
    cyc(2);
    RESET = 1'b1; cyc(2); RESET = 1'b0;
    mp = 0; mz = 0; expect_req();
    wait_start(1, got);
    total++; if (!got || o_cx !== pcx[0] || o_zoom !== 0) $display("FAIL reset_mid: got=%b cx=%h zoom=%0d want 1 %h 0", got, o_cx, o_zoom, pcx[0]); else passed++;
    done();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_zoom_in();
    test_back_to_back();
    test_limits();
    test_combo();
`ifdef VIEW_AUTO_ZOOM_EN
    test_auto();
`endif
    test_reset_mid();
    cyc(3);
    total++; if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d requests never issued, want 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
